// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: walks one logical_unit through clear, MAC over the
// input stream, bias add and a registered result hand-off for one neuron.
module neuron_mac_sequencer #(
   parameter int WORD_SIZE    = 16,
   parameter int INPUT_LENGTH = 8,
   parameter int LU_LATENCY   = 1,
   parameter int ADDR_WIDTH   = $clog2(INPUT_LENGTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WORD_SIZE-1:0]  data_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0]  lu_data_o,
   output logic                  lu_sum_en_o,
   output logic                  lu_add_bias_o,
   output logic                  lu_reset_o,
   input  logic [WORD_SIZE-1:0]  lu_result_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WORD_SIZE-1:0]  data_o
);

   localparam int CW = $clog2(INPUT_LENGTH + LU_LATENCY + 2);
   localparam logic [CW-1:0] LAST_IN = CW'(INPUT_LENGTH - 1);
   localparam logic [CW-1:0] LAST_DR = CW'(LU_LATENCY);

   typedef enum logic [2:0] {
      CLEAR,
      ACCUM,
      BIAS,
      DRAIN,
      OUT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          accept;
   logic          sample;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= CLEAR;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // count indexes weights in ACCUM and times the LU pipeline in DRAIN
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      accept  = 1'b0;
      sample  = 1'b0;
      unique case (state_q)
         CLEAR: begin
            state_d = ACCUM;
            count_d = '0;
         end
         ACCUM: begin
            if (valid_i) begin
               accept = 1'b1;
               if (count_q == LAST_IN) begin
                  state_d = BIAS;
                  count_d = '0;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         BIAS: begin
            state_d = DRAIN;
            count_d = '0;
         end
         DRAIN: begin
            if (count_q == LAST_DR) begin
               sample  = 1'b1;
               state_d = OUT;
               count_d = '0;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         OUT: begin
            if (ready_i) begin
               state_d = CLEAR;
            end
         end
         default: begin
            state_d = CLEAR;
            count_d = '0;
         end
      endcase
   end

   assign ready_o    = (state_q == ACCUM);
   assign valid_o    = (state_q == OUT);
   assign lu_reset_o = (state_q == CLEAR);
   assign mem_addr_o = (state_q == BIAS)  ? ADDR_WIDTH'(INPUT_LENGTH) :
                       (state_q == ACCUM) ? count_q[ADDR_WIDTH-1:0] :
                                            '0;

   // issue stage: one register so LU controls line up with ROM read data
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         lu_data_o     <= '0;
         lu_sum_en_o   <= 1'b0;
         lu_add_bias_o <= 1'b0;
         data_o        <= '0;
      end else begin
         lu_sum_en_o   <= accept || (state_q == BIAS);
         lu_add_bias_o <= (state_q == BIAS);
         if (accept) begin
            lu_data_o <= data_i;
         end
         if (sample) begin
            data_o <= lu_result_i;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Randomised self-checking bench for neuron_mac_sequencer, run side by side
// at LU latencies 1 and 3 with behavioural LU and weight ROM models.
`timescale 1ns/1ps
module tb_neuron_mac_sequencer;

   localparam int WS   = 16;
   localparam int IL   = 4;
   localparam int FRAC = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int lat,
                      input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lat=%0d got=%0h want=%0h t=%0t",
                  name, lat, act, exp, $time);
      end
   endtask

   function automatic logic signed [WS-1:0] sat16(input longint v);
      logic signed [WS-1:0] r;
      if (v > 32767)       r = 16'sh7FFF;
      else if (v < -32768) r = 16'sh8000;
      else                 r = v[WS-1:0];
      return r;
   endfunction

   // Q4.12 multiply-accumulate with saturation, as the LU defines it
   function automatic logic signed [WS-1:0] mac_step(
      input logic signed [WS-1:0] a,
      input logic signed [WS-1:0] x,
      input logic signed [WS-1:0] w);
      longint p;
      p = (longint'(x) * longint'(w)) >>> FRAC;
      return sat16(longint'(a) + p);
   endfunction

   function automatic logic [WS-1:0] ref_neuron(
      input logic [IL-1:0][WS-1:0] x,
      input logic [IL-1:0][WS-1:0] w,
      input logic [WS-1:0]         b);
      logic signed [WS-1:0] a;
      a = '0;
      for (int i = 0; i < IL; i++) a = mac_step(a, x[i], w[i]);
      return sat16(longint'(a) + longint'($signed(b)));
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gl
      localparam int LAT = (g == 0) ? 1 : 3;

      logic          rstn      = 1'b1;
      logic          valid_in  = 1'b0;
      logic          ready_in  = 1'b0;
      logic [WS-1:0] din       = '0;
      logic          ready_out;
      logic [2:0]    addr;
      logic [WS-1:0] lu_data;
      logic          sum_en;
      logic          add_bias;
      logic          lu_rst;
      logic [WS-1:0] lu_res;
      logic          valid_out;
      logic [WS-1:0] dout;
      logic          fin = 1'b0;

      neuron_mac_sequencer #(
         .WORD_SIZE(WS), .INPUT_LENGTH(IL), .LU_LATENCY(LAT)
      ) dut (
         .clk_i(clk), .reset_n_i(rstn),
         .valid_i(valid_in), .ready_o(ready_out), .data_i(din),
         .mem_addr_o(addr), .lu_data_o(lu_data),
         .lu_sum_en_o(sum_en), .lu_add_bias_o(add_bias),
         .lu_reset_o(lu_rst), .lu_result_i(lu_res),
         .valid_o(valid_out), .ready_i(ready_in), .data_o(dout)
      );

      // weight ROM with a registered read and the LU accumulator
      logic [WS-1:0]        rom [0:IL];
      logic [WS-1:0]        rom_q = '0;
      logic signed [WS-1:0] acc   = '0;
      logic [WS-1:0]        dly [0:3];

      always @(posedge clk) begin
         rom_q <= rom[addr];
         if (lu_rst)
            acc <= '0;
         else if (sum_en)
            acc <= add_bias ? sat16(longint'(acc) + longint'($signed(rom_q)))
                            : mac_step(acc, lu_data, rom_q);
         dly[0] <= acc;
         for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
      end

      if (LAT == 1) begin : l1
         assign lu_res = acc;
      end else begin : ln
         assign lu_res = dly[LAT-2];
      end

      // cycle-level compare process
      int            cyc    = 0;
      int            nacc   = 0;
      int            npulse = 0;
      int            nbias  = 0;
      int            t_last = 0;
      logic          last_bias    = 1'b0;
      logic          bias_due     = 1'b0;
      logic          expect_ready = 1'b0;
      logic          vout_q = 1'b0;
      logic          rin_q  = 1'b0;
      logic [WS-1:0] dout_q = '0;
      logic [WS-1:0] exp_q [$];

      always @(negedge clk) begin
         cyc++;
         if (!rstn) begin
            chk("rst_valid", LAT, valid_out, 0);
            chk("rst_ready", LAT, ready_out, 0);
            chk("rst_data", LAT, dout, 0);
            chk("rst_lu_reset", LAT, lu_rst, 1);
            chk("rst_issue", LAT, {sum_en, add_bias, addr, lu_data}, 0);
            nacc = 0; npulse = 0; nbias = 0;
            bias_due = 0; expect_ready = 0; vout_q = 0; rin_q = 0;
         end else begin
            chk("reset_sum_overlap", LAT, lu_rst & sum_en, 0);
            if (expect_ready)
               chk("ready_after_clear", LAT, {ready_out, lu_rst}, 2'b10);
            expect_ready = lu_rst;
            if (lu_rst) begin
               nacc = 0; npulse = 0; nbias = 0;
            end
            if (sum_en) begin
               npulse++;
               last_bias = add_bias;
               if (add_bias) nbias++;
            end
            if (bias_due)
               chk("bias_addr", LAT, {ready_out, addr}, {1'b0, 3'd4});
            bias_due = 0;
            if (ready_out) begin
               chk("addr", LAT, addr, nacc);
               chk("ready_with_valid", LAT, valid_out, 0);
               if (valid_in) begin
                  nacc++;
                  if (nacc == IL) begin
                     t_last   = cyc;
                     bias_due = 1;
                  end
               end
            end
            if (valid_out && !vout_q) begin
               chk("latency", LAT, cyc, t_last + LAT + 3);
               chk("n_accepts", LAT, nacc, IL);
            end
            if (valid_out && vout_q && !rin_q)
               chk("hold", LAT, dout, dout_q);
            if (valid_out && ready_in) begin
               chk("sum_pulses", LAT, npulse, IL + 1);
               chk("bias_pulses", LAT, nbias, 1);
               chk("bias_last", LAT, last_bias, 1);
               if (exp_q.size() == 0)
                  chk("result_queue", LAT, exp_q.size(), 1);
               else
                  chk("data_o", LAT, dout, exp_q.pop_front());
            end
            vout_q = valid_out;
            rin_q  = ready_in;
            dout_q = dout;
         end
      end

      task automatic tick();
         @(posedge clk);
         #1;
      endtask

      task automatic send(input logic [WS-1:0] x);
         logic took;
         took     = 1'b0;
         valid_in = 1'b1;
         din      = x;
         for (int b = 0; b < 50 && !took; b++) begin
            @(negedge clk);
            took = ready_out;
            tick();
         end
         valid_in = 1'b0;
         if (!took) chk("accept_timeout", LAT, took, 1);
      endtask

      task automatic vec(input logic [IL-1:0][WS-1:0] x,
                         input logic [IL-1:0][WS-1:0] w,
                         input logic [WS-1:0]         b,
                         input logic [IL-1:0][3:0]    gp,
                         input int                    stall,
                         input bit                    abort);
         for (int i = 0; i < IL; i++) rom[i] = w[i];
         rom[IL] = b;
         if (!abort) exp_q.push_back(ref_neuron(x, w, b));
         for (int i = 0; i < (abort ? 2 : IL); i++) begin
            repeat (gp[i]) tick();
            send(x[i]);
         end
         if (abort) begin
            rstn = 1'b0;
            repeat (2) tick();
            rstn = 1'b1;
            return;
         end
         ready_in = (stall == 0);
         for (int k = 0; k < 60 && !valid_out; k++) tick();
         chk("valid_timeout", LAT, valid_out, 1);
         if (stall > 0) begin
            valid_in = 1'b1;
            din      = 16'hDEAD;
            repeat (stall) tick();
            valid_in = 1'b0;
            ready_in = 1'b1;
         end
         tick();
         ready_in = 1'b0;
         chk("after_handshake", LAT, {valid_out, lu_rst}, 2'b01);
      endtask

      initial begin
         logic [IL-1:0][WS-1:0] xv, wv, ones, halves;
         logic [IL-1:0][3:0]    gv;
         logic [WS-1:0]         bv;
         ones   = {IL{16'h1000}};
         halves = {IL{16'h0800}};
         for (int i = 0; i <= IL; i++) rom[i] = '0;
         #1 rstn = 1'b0;
         repeat (3) tick();
         rstn = 1'b1;
         chk("release_clear", LAT, {lu_rst, ready_out}, 2'b10);
         tick();
         chk("release_ready", LAT, {lu_rst, ready_out}, 2'b01);

         vec(ones, halves, 16'h0400, '0, 0, 0);
         chk("t2_literal", LAT, dout, 16'h2400);
         vec(ones, halves, 16'h0400, {4'd1, 4'd0, 4'd2, 4'd0}, 0, 0);
         chk("t3_literal", LAT, dout, 16'h2400);
         vec(ones, halves, 16'h0400, '0, 10, 0);
         vec({IL{16'h3000}}, {IL{16'h7000}}, 16'h0400, '0, 0, 1);
         vec(ones, halves, 16'h0400, '0, 0, 0);
         chk("t5_literal", LAT, dout, 16'h2400);
         vec({IL{16'h7FFF}}, {IL{16'h7FFF}}, 16'h0400, '0, 0, 0);
         chk("t6_literal", LAT, dout, 16'h7FFF);

         for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < IL; j++) begin
               xv[j] = WS'($urandom);
               wv[j] = WS'($urandom);
               gv[j] = 4'($urandom_range(0, 2));
               if (n % 2 == 1) begin
                  xv[j] = WS'($signed(xv[j]) >>> 3);
                  wv[j] = WS'($signed(wv[j]) >>> 3);
               end
            end
            bv = WS'($signed(WS'($urandom)) >>> 2);
            vec(xv, wv, bv, gv, int'($urandom_range(0, 3)), 0);
         end
         repeat (3) tick();
         fin = 1'b1;
      end
   end

   initial begin
      chk("pin_half", 0,
          ref_neuron({IL{16'h1000}}, {IL{16'h0800}}, 16'h0400), 16'h2400);
      chk("pin_sat", 0,
          ref_neuron({IL{16'h7FFF}}, {IL{16'h7FFF}}, 16'h0400), 16'h7FFF);
      chk("pin_neg", 0,
          ref_neuron({IL{16'h1000}}, {IL{16'hF000}}, 16'h0000), 16'hC000);
      for (int i = 0; i < 20000 && !(gl[0].fin && gl[1].fin); i++)
         @(posedge clk);
      chk("finished", 0, gl[0].fin && gl[1].fin, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
